// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam int          ENTRY_XLEN  = 32;

   // Queue entry layout; the FIFO stores {instr, pc} in this order.
   typedef struct packed {
      logic [ENTRY_XLEN-1:0] instr;
      logic [ENTRY_XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x WIDTH synchronous FIFO with occupancy count, synchronous clear and
// active-low asynchronous reset of its control state.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

   overflow_check: assert property (@(posedge clk) disable iff (!reset_n)
      !(push && full && !pop));

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch unit: PC generator, credit-limited imem requests and a
// prefetch queue to decode. Define FETCH_STATS_EN to add statistics counters.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            fetch_en,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_instr,
   output logic [XLEN-1:0] dec_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]     stat_fetched,
   output logic [31:0]     stat_flushed,
   output logic [31:0]     stat_stall
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e     state_q;
   fetch_state_e     state_d;
   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  rsp_pc;
   logic [XLEN-1:0]  redirect_aligned;
   logic [CW-1:0]    outstanding;
   logic [CW-1:0]    drop_cnt;
   logic [CW-1:0]    count;
   logic [CW-1:0]    out_after;
   logic [CW-1:0]    drop_after;
   logic             req_fire;
   logic             rsp_accept;
   logic             rsp_drop;
   logic             pop;
   logic [2*XLEN-1:0] fifo_dout;

   assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

   // Credit rule: queued plus in-flight never exceeds DEPTH, so pushes always fit.
   assign imem_req_valid = (state_q == RUN)
                        && (({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH))
                        && (outstanding < CW'(MAX_OUTSTANDING))
                        && !redirect_valid;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_drop   = imem_rsp_valid && (redirect_valid || (state_q == FLUSH));
   assign rsp_accept = imem_rsp_valid && !rsp_drop;
   assign out_after  = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
   assign drop_after = drop_cnt - CW'(imem_rsp_valid);

   assign dec_valid = (count != '0) && !redirect_valid;
   assign pop       = dec_valid && dec_ready;
   assign dec_instr = fifo_dout[2*XLEN-1:XLEN];
   assign dec_pc    = fifo_dout[XLEN-1:0];

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (redirect_valid),
      .push    (rsp_accept),
      .pop     (pop),
      .din     ({imem_rsp_data, rsp_pc}),
      .dout    (fifo_dout),
      .count   (count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fetch_en) state_d = RUN;
         RUN:     if (!fetch_en) state_d = IDLE;
         FLUSH:   if (drop_after == '0) state_d = fetch_en ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
      if (redirect_valid) begin
         if (out_after != '0) state_d = FLUSH;
         else                 state_d = fetch_en ? RUN : IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= out_after;
         if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            rsp_pc   <= redirect_aligned;
            drop_cnt <= out_after;
         end else begin
            if (req_fire)   fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
            if (rsp_accept) rsp_pc   <= rsp_pc + XLEN'(INSTR_BYTES);
            if (rsp_drop)   drop_cnt <= drop_after;
         end
      end
   end

`ifdef FETCH_STATS_EN
   function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [31:0] inc);
      logic [32:0] sum;
      sum = {1'b0, acc} + {1'b0, inc};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   logic [31:0] flush_inc;
   assign flush_inc = (redirect_valid ? 32'(count) : 32'd0) + 32'(rsp_drop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_fetched <= '0;
         stat_flushed <= '0;
         stat_stall   <= '0;
      end else begin
         stat_fetched <= sat_add(stat_fetched, 32'(pop));
         stat_flushed <= sat_add(stat_flushed, flush_inc);
         stat_stall   <= sat_add(stat_stall,
                                 32'(dec_ready && !dec_valid && (state_q == RUN)));
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a variable-latency memory responder.
module tb_fetch_queue_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_flushed;
   logic [31:0] stat_stall;
`endif

   always #5 clk = ~clk;

   fetch_queue_unit #(
      .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc)
`ifdef FETCH_STATS_EN
      ,
      .stat_fetched   (stat_fetched),
      .stat_flushed   (stat_flushed),
      .stat_stall     (stat_stall)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic        fen;
      logic        drdy;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_req_v;
      logic [31:0] exp_addr;
      logic        exp_dec_v;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   pend_t       pend[$];
   vec_t        tbl[13];
   int          lat;
   int          cyc;
   int          req_cnt;
   int          rsp_cnt;
   int          pops;
   logic        req_seen;
   logic        pop_seen;
   logic [31:0] last_req_addr;
   logic [31:0] last_pop_pc;
   logic [31:0] last_pop_instr;
   int          vectors;
   int          miscompares;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, let the memory
   // model answer, then sample just after and log handshakes.
   task automatic cycle(input logic fen, input logic drdy, input logic redir,
                        input logic [31:0] rpc);
      @(negedge clk);
      fetch_en       = fen;
      dec_ready      = drdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pend[0].addr + 32'h100;
         void'(pend.pop_front());
         rsp_cnt++;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
      #1;
      req_seen = imem_req_valid && imem_req_ready;
      pop_seen = dec_valid && dec_ready;
      if (req_seen) begin
         pend.push_back('{addr: imem_req_addr, due: cyc + lat});
         last_req_addr = imem_req_addr;
         req_cnt++;
      end
      if (pop_seen) begin
         last_pop_pc    = dec_pc;
         last_pop_instr = dec_instr;
         pops++;
      end
      cyc++;
   endtask

   task automatic clear_log();
      pend.delete();
      imem_rsp_valid = 1'b0;
      cyc     = 0;
      req_cnt = 0;
      rsp_cnt = 0;
      pops    = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n        = 1'b0;
      fetch_en       = 1'b0;
      dec_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      clear_log();
      repeat (2) @(negedge clk);
      #1;
      chk("reset req_valid", 32'(imem_req_valid), 32'd0);
      chk("reset dec_valid", 32'(dec_valid), 32'd0);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_pc;
      logic        got_req;
      logic        got_pop;
      int          base_rsp;
      int          base_pops;

      vectors        = 0;
      miscompares    = 0;
      imem_req_ready = 1'b1;
      imem_rsp_data  = 32'h0;
      reset_n        = 1'b0;
      lat            = 1;

      //          fen   drdy  redir rpc           req_v addr          dec_v pc            instr
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        32'h0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0,        32'h0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0,        32'h100};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h4,        32'h104};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h203,      1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h200,      1'b0, 32'h0,        32'h0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h204,      1'b0, 32'h0,        32'h0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h208,      1'b1, 32'h200,      32'h300};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h20C,      1'b1, 32'h204,      32'h304};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h208,      32'h308};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h20C,      32'h30C};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0};

      // Streaming, same-cycle redirect/response/pop, then fetch_en drop.
      do_reset();
      for (int r = 0; r < 13; r++) begin
         cycle(tbl[r].fen, tbl[r].drdy, tbl[r].redir, tbl[r].rpc);
         chk($sformatf("row%0d req_valid", r), 32'(imem_req_valid), 32'(tbl[r].exp_req_v));
         if (tbl[r].exp_req_v)
            chk($sformatf("row%0d req_addr", r), imem_req_addr, tbl[r].exp_addr);
         chk($sformatf("row%0d dec_valid", r), 32'(dec_valid), 32'(tbl[r].exp_dec_v));
         if (tbl[r].exp_dec_v) begin
            chk($sformatf("row%0d dec_pc", r), dec_pc, tbl[r].exp_pc);
            chk($sformatf("row%0d dec_instr", r), dec_instr, tbl[r].exp_instr);
         end
      end

      // Decode stalled: queue fills, requests stop, then drains in order.
      do_reset();
      lat = 1;
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall req_count", 32'(req_cnt), 32'd4);
      chk("stall req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall head_valid", 32'(dec_valid), 32'd1);
      chk("stall head_pc", dec_pc, 32'h0);
      exp_pc  = 32'h0;
      got_req = 1'b0;
      for (int i = 0; i < 20 && !(got_req && exp_pc == 32'h10); i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (pop_seen && exp_pc < 32'h10) begin
            chk("drain pc", last_pop_pc, exp_pc);
            chk("drain instr", last_pop_instr, exp_pc + 32'h100);
            exp_pc = exp_pc + 32'h4;
         end
         if (req_seen && !got_req) begin
            got_req = 1'b1;
            chk("resume addr", last_req_addr, 32'h10);
         end
      end
      chk("drain complete", exp_pc, 32'h10);
      chk("resume seen", 32'(got_req), 32'd1);

      // 3-cycle memory, redirect with two requests in flight.
      do_reset();
      lat = 3;
      for (int i = 0; i < 10 && req_cnt < 2; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
      chk("pre-redirect reqs", 32'(req_cnt), 32'd2);
      base_rsp  = rsp_cnt;
      base_pops = pops;
      cycle(1'b1, 1'b1, 1'b1, 32'h83);
      chk("redirect dec_valid", 32'(dec_valid), 32'd0);
      chk("redirect req_valid", 32'(imem_req_valid), 32'd0);
      got_req = 1'b0;
      got_pop = 1'b0;
      for (int i = 0; i < 30 && !got_pop; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (req_seen && !got_req) begin
            got_req = 1'b1;
            chk("stale rsps before req", 32'(rsp_cnt - base_rsp), 32'd2);
            chk("redirect req_addr", last_req_addr, 32'h80);
         end
         if (pop_seen && !got_pop) begin
            got_pop = 1'b1;
            chk("redirect first pc", last_pop_pc, 32'h80);
            chk("redirect first instr", last_pop_instr, 32'h180);
            chk("no stale pops", 32'(pops - base_pops), 32'd1);
         end
      end
      chk("redirect pop seen", 32'(got_pop), 32'd1);
`ifdef FETCH_STATS_EN
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk("stat_flushed", stat_flushed, 32'd2);
      chk("stat_fetched", stat_fetched, 32'(pops));
`endif

      // Asynchronous reset pulse between clock edges with a full queue.
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      chk("pre-reset dec_valid", 32'(dec_valid), 32'd1);
      #1;
      reset_n = 1'b0;
      clear_log();
      #1;
      chk("async reset dec_valid", 32'(dec_valid), 32'd0);
      chk("async reset req_valid", 32'(imem_req_valid), 32'd0);
      reset_n = 1'b1;
      lat     = 1;
      got_req = 1'b0;
      got_pop = 1'b0;
      for (int i = 0; i < 20 && !got_pop; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'h0);
         if (req_seen && !got_req) begin
            got_req = 1'b1;
            chk("restart req_addr", last_req_addr, 32'h0);
         end
         if (pop_seen && !got_pop) begin
            got_pop = 1'b1;
            chk("restart first pc", last_pop_pc, 32'h0);
            chk("restart first instr", last_pop_instr, 32'h100);
         end
      end
      chk("restart pop seen", 32'(got_pop), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
